sort_result_stats: RTL and testbench

- Downstream consumer of top_sorter; takes the sorted array as a stream of SIZE signed 32-bit words, index 0 first.
- Produces per-frame min, max, median and sum, plus an order check flagging any non-ascending pair.
- Presents results once per frame on a valid/ready handshake to the next stage or the bench scoreboard.

---
 rtl/sort_result_stats.sv | 129 ++++++++++++
 tb/tb_sort_result_stats.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_result_stats.sv
// sort_result_stats: per-frame min/max/median/sum of a sorted word stream,
// with an ascending-order check and a valid/ready result handshake.
module sort_result_stats #(
    parameter int SIZE  = 8,
    parameter int SUM_W = 35
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_min,
    output logic [31:0]      out_max,
    output logic [31:0]      out_median,
    output logic [SUM_W-1:0] out_sum,
    output logic             order_err,
    output logic             ovr_err,
    output logic             busy
);

    localparam int CW = $clog2(SIZE);
    localparam logic [CW-1:0] MID  = CW'(SIZE / 2);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [31:0]      prev_q;
    logic [31:0]      min_q;
    logic [31:0]      max_q;
    logic [31:0]      med_q;
    logic [SUM_W-1:0] sum_q;
    logic             valid_q;
    logic             order_q;
    logic             ovr_q;

    logic [SUM_W-1:0] word_sext;
    logic [SUM_W-1:0] sum_d;
    logic             descend;

    assign word_sext = {{(SUM_W-32){in_data[31]}}, in_data};
    assign sum_d     = sum_q + word_sext;
    assign descend   = $signed(in_data) < $signed(prev_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prev_q  <= '0;
            min_q   <= '0;
            max_q   <= '0;
            med_q   <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            order_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (clr) begin
            // Abort keeps the last result fields; only control and flags reset.
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            order_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        min_q   <= in_data;
                        prev_q  <= in_data;
                        sum_q   <= word_sext;
                        cnt_q   <= CW'(1);
                        order_q <= 1'b0;
                        ovr_q   <= 1'b0;
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (in_valid) begin
                        if (descend) begin
                            order_q <= 1'b1;
                        end
                        prev_q <= in_data;
                        sum_q  <= sum_d;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == MID) begin
                            med_q <= in_data;
                        end
                        if (cnt_q == LAST) begin
                            max_q   <= in_data;
                            valid_q <= 1'b1;
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Words arriving here are dropped, never start a frame.
                    if (in_valid) begin
                        ovr_q <= 1'b1;
                    end
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid  = valid_q;
    assign out_min    = min_q;
    assign out_max    = max_q;
    assign out_median = med_q;
    assign out_sum    = sum_q;
    assign order_err  = order_q;
    assign ovr_err    = ovr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sort_result_stats.sv
// Bench for sort_result_stats: directed frames with literal expectations plus
// randomized traffic checked each cycle against a queue-based frame model.
module tb_sort_result_stats;

    localparam int SIZE  = 8;
    localparam int SUM_W = 35;

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             clr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_min;
    logic [31:0]      out_max;
    logic [31:0]      out_median;
    logic [SUM_W-1:0] out_sum;
    logic             order_err;
    logic             ovr_err;
    logic             busy;

    int checks = 0;
    int errors = 0;

    sort_result_stats #(
        .SIZE (SIZE),
        .SUM_W(SUM_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_min   (out_min),
        .out_max   (out_max),
        .out_median(out_median),
        .out_sum   (out_sum),
        .order_err (order_err),
        .ovr_err   (ovr_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chks(input string name, input logic [SUM_W-1:0] act,
                        input logic [SUM_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Frame model: words of the frame in progress, plus the finished result.
    int               m_q[$];
    bit               m_hold;
    bit               m_ovr;
    logic [31:0]      m_min;
    logic [31:0]      m_max;
    logic [31:0]      m_med;
    logic [SUM_W-1:0] m_sum;
    bit               m_ord;

    task automatic model_reset();
        m_q.delete();
        m_hold = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic model_finish();
        longint s = 0;
        m_ord = 1'b0;
        foreach (m_q[i]) s += longint'(m_q[i]);
        for (int i = 0; i + 1 < SIZE; i++) begin
            if (m_q[i+1] < m_q[i]) m_ord = 1'b1;
        end
        m_min = m_q[0];
        m_max = m_q[SIZE-1];
        m_med = m_q[SIZE/2];
        m_sum = SUM_W'(s);
        m_q.delete();
        m_hold = 1'b1;
    endtask

    task automatic model_step();
        if (clr) begin
            model_reset();
        end else if (m_hold) begin
            if (in_valid) m_ovr = 1'b1;
            if (out_ready) m_hold = 1'b0;
        end else if (in_valid) begin
            if (m_q.size() == 0) m_ovr = 1'b0;
            m_q.push_back(int'(in_data));
            if (m_q.size() == SIZE) model_finish();
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            chk1("rst_out_valid", out_valid, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chks("rst_sum", out_sum, '0);
            chk1("rst_order", order_err, 1'b0);
            chk1("rst_ovr", ovr_err, 1'b0);
        end else begin
            chk1("out_valid", out_valid, m_hold);
            chk1("busy", busy, m_hold || (m_q.size() != 0));
            if (m_hold) begin
                chk32("min", out_min, m_min);
                chk32("max", out_max, m_max);
                chk32("median", out_median, m_med);
                chks("sum", out_sum, m_sum);
                chk1("order_err", order_err, m_ord);
                chk1("ovr_err", ovr_err, m_ovr);
            end
        end
    end

    logic [31:0] asc[SIZE]  = '{32'hFFFFFFFB, 32'hFFFFFFFF, 32'd0, 32'd3,
                                32'd3, 32'd7, 32'd100, 32'd2000};
    logic [31:0] uns[SIZE]  = '{32'd1, 32'd2, 32'd3, 32'd9,
                                32'd4, 32'd5, 32'd6, 32'd7};
    logic [31:0] run_val;

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        clr       = 1'b0;
        out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk1("reset_valid", out_valid, 1'b0);
        chk32("reset_min", out_min, 32'd0);
        chk32("reset_median", out_median, 32'd0);
        chk1("reset_busy", busy, 1'b0);
        rstn = 1'b1;

        // Ascending frame, back to back.
        for (int i = 0; i < SIZE; i++) drive(1'b1, asc[i]);
        chk1("asc_valid", out_valid, 1'b1);
        chk32("asc_min", out_min, 32'hFFFFFFFB);
        chk32("asc_max", out_max, 32'd2000);
        chk32("asc_median", out_median, 32'd3);
        chks("asc_sum", out_sum, 35'd2107);
        chk1("asc_order", order_err, 1'b0);
        chk1("asc_ovr", ovr_err, 1'b0);
        drive(1'b0, '0);
        chk1("asc_drop", out_valid, 1'b0);

        // Unsorted frame.
        for (int i = 0; i < SIZE; i++) drive(1'b1, uns[i]);
        chk32("uns_max", out_max, 32'd7);
        chk32("uns_median", out_median, 32'd4);
        chks("uns_sum", out_sum, 35'd37);
        chk1("uns_order", order_err, 1'b1);
        drive(1'b0, '0);

        // Gapped input with a stalled consumer, then overrun words.
        out_ready = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            drive(1'b1, 32'(i));
            drive(1'b0, '0);
        end
        repeat (4) drive(1'b0, '0);
        chk1("gap_valid", out_valid, 1'b1);
        chks("gap_sum", out_sum, 35'd28);
        chk32("gap_median", out_median, 32'd4);
        chk32("gap_max", out_max, 32'd7);
        chk1("gap_busy", busy, 1'b1);
        drive(1'b1, 32'd99);
        chk1("ovr_flag", ovr_err, 1'b1);
        chks("ovr_sum", out_sum, 35'd28);
        chk32("ovr_min", out_min, 32'd0);
        out_ready = 1'b1;
        drive(1'b1, 32'd77);
        chk1("hs_valid", out_valid, 1'b0);
        chk1("hs_busy", busy, 1'b0);
        for (int i = 0; i < SIZE; i++) drive(1'b1, 32'(10 + i));
        chk32("next_min", out_min, 32'd10);
        chk1("next_ovr", ovr_err, 1'b0);
        drive(1'b0, '0);

        // clr mid-frame, colliding with a word, then all-most-negative frame.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'(i + 1));
        clr = 1'b1;
        drive(1'b1, 32'd5);
        clr = 1'b0;
        chk1("clr_busy", busy, 1'b0);
        chk1("clr_valid", out_valid, 1'b0);
        for (int i = 0; i < SIZE; i++) drive(1'b1, 32'h80000000);
        chks("neg_sum", out_sum, 35'h400000000);
        chk32("neg_min", out_min, 32'h80000000);
        chk32("neg_max", out_max, 32'h80000000);
        chk32("neg_median", out_median, 32'h80000000);
        chk1("neg_order", order_err, 1'b0);
        drive(1'b0, '0);

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 4; i++) drive(1'b1, 32'(50 + i));
        in_valid = 1'b0;
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        chk1("arst_busy", busy, 1'b0);
        chks("arst_sum", out_sum, '0);
        chk32("arst_min", out_min, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < SIZE; i++) drive(1'b1, 32'(20 + 2 * i));
        chk32("post_min", out_min, 32'd20);
        chk32("post_max", out_max, 32'd34);
        chks("post_sum", out_sum, 35'd216);
        drive(1'b0, '0);

        // Randomized traffic.
        run_val = $urandom();
        for (int c = 0; c < 3000; c++) begin
            logic        v;
            logic [31:0] d;
            clr       = ($urandom_range(0, 99) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            v         = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) begin
                d = $urandom();
            end else begin
                run_val = run_val + $urandom_range(0, 20);
                d = run_val;
            end
            drive(v, d);
        end
        clr       = 1'b0;
        out_ready = 1'b1;
        repeat (3) drive(1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
